// File: rtl/video_capture_pkg.sv
// Shared types and constants for the video capture block: FSM state encodings,
// counter sizing, RGB444 packing width and default active geometry.
package video_capture_pkg;

  localparam int DEF_HA   = 640;
  localparam int DEF_VA   = 480;
  localparam int CNT_W    = 10;
  localparam int RGB444_W = 12;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} lock_state_e;
  typedef enum logic [1:0] {IDLE, ARMED, RUN}        cap_state_e;

endpackage

// File: rtl/video_timing_meter.sv
// Sync edge detection plus x/y pixel counters; with VIDEO_CAPTURE_TIMING_EN it
// also measures total clocks per line and total lines per frame.
module video_timing_meter
  import video_capture_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             vs_i,
  input  logic             hs_i,
  input  logic             de_i,
  output logic             frame_edge_o,
  output logic             line_end_o,
  output logic [CNT_W-1:0] x_o,
  output logic [CNT_W-1:0] y_o,
  output logic [CNT_W-1:0] htotal_o,
  output logic [CNT_W-1:0] vtotal_o
);

  logic             vs_prev_q, de_prev_q;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;

  assign frame_edge_o = vs_prev_q & ~vs_i;
  assign line_end_o   = de_prev_q & ~de_i;
  assign x_o          = x_q;
  assign y_o          = y_q;

  always_comb begin
    x_d = x_q;
    if (line_end_o)                   x_d = '0;
    else if (de_i && x_q != CNT_MAX)  x_d = x_q + CNT_W'(1);
    y_d = y_q;
    if (frame_edge_o)                        y_d = '0;
    else if (line_end_o && y_q != CNT_MAX)   y_d = y_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_prev_q <= 1'b0;
      de_prev_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      vs_prev_q <= vs_i;
      de_prev_q <= de_i;
      x_q       <= x_d;
      y_q       <= y_d;
    end
  end

`ifdef VIDEO_CAPTURE_TIMING_EN
  logic             hs_prev_q, hs_fall;
  logic [CNT_W-1:0] hcnt_q, vcnt_q, htot_q, vtot_q;

  assign hs_fall  = hs_prev_q & ~hs_i;
  assign htotal_o = htot_q;
  assign vtotal_o = vtot_q;

  // hcnt restarts at 1 so that on the next fall it already holds the period.
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_prev_q <= 1'b0;
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      htot_q    <= '0;
      vtot_q    <= '0;
    end else begin
      hs_prev_q <= hs_i;
      if (hs_fall) begin
        htot_q <= hcnt_q;
        hcnt_q <= CNT_W'(1);
      end else if (hcnt_q != CNT_MAX) begin
        hcnt_q <= hcnt_q + CNT_W'(1);
      end
      if (frame_edge_o) begin
        vtot_q <= vcnt_q;
        vcnt_q <= hs_fall ? CNT_W'(1) : '0;
      end else if (hs_fall && vcnt_q != CNT_MAX) begin
        vcnt_q <= vcnt_q + CNT_W'(1);
      end
    end
  end
`else
  logic unused_hs;
  assign unused_hs = hs_i;
  assign htotal_o  = '0;
  assign vtotal_o  = '0;
`endif

endmodule

// File: rtl/video_capture.sv
// Single-frame video grabber: locks onto the incoming timing, then writes one
// RGB444 frame on request. Optional VIDEO_CAPTURE_TIMING_EN adds total measurement.
module video_capture
  import video_capture_pkg::*;
#(
  parameter int HA         = DEF_HA,
  parameter int VA         = DEF_VA,
  parameter int ADDR_WIDTH = 18
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            vid_r,
  input  logic [7:0]            vid_g,
  input  logic [7:0]            vid_b,
  input  logic                  vid_hs,
  input  logic                  vid_vs,
  input  logic                  vid_de,
  input  logic                  capture_start,
  output logic                  locked,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  capture_err,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [RGB444_W-1:0]   wr_data,
  output logic [CNT_W-1:0]      meas_width,
  output logic [CNT_W-1:0]      meas_height,
  output logic [CNT_W-1:0]      meas_htotal,
  output logic [CNT_W-1:0]      meas_vtotal
);

  localparam logic [CNT_W-1:0] HA_C = CNT_W'(HA);
  localparam logic [CNT_W-1:0] VA_C = CNT_W'(VA);

  logic [7:0]       r_q, g_q, b_q;
  logic             hs_q, vs_q, de_q;
  logic             frame_edge, line_end, frame_match, wr_hit;
  logic [CNT_W-1:0] x, y;

  logic [CNT_W-1:0]      meas_width_q, meas_height_q;
  logic                  width_err_q;
  lock_state_e           lock_q;
  logic                  match_cnt_q, locked_q;
  cap_state_e            cap_q;
  logic                  busy_q, done_q, err_q;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [RGB444_W-1:0]   wr_data_q;
  logic [11:0]           unused_lo;

  assign unused_lo = {r_q[3:0], g_q[3:0], b_q[3:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      {r_q, g_q, b_q}    <= '0;
      {hs_q, vs_q, de_q} <= '0;
    end else begin
      {r_q, g_q, b_q}    <= {vid_r, vid_g, vid_b};
      {hs_q, vs_q, de_q} <= {vid_hs, vid_vs, vid_de};
    end
  end

  video_timing_meter u_meter (
    .clk          (clk),
    .reset        (reset),
    .vs_i         (vs_q),
    .hs_i         (hs_q),
    .de_i         (de_q),
    .frame_edge_o (frame_edge),
    .line_end_o   (line_end),
    .x_o          (x),
    .y_o          (y),
    .htotal_o     (meas_htotal),
    .vtotal_o     (meas_vtotal)
  );

  assign frame_match = (y == VA_C) && !width_err_q;

  // Any short or long line poisons the whole frame until the next boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      meas_width_q  <= '0;
      meas_height_q <= '0;
      width_err_q   <= 1'b0;
    end else begin
      if (line_end) meas_width_q <= x;
      if (frame_edge) begin
        meas_height_q <= y;
        width_err_q   <= 1'b0;
      end else if (line_end && x != HA_C) begin
        width_err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q      <= SEARCH;
      match_cnt_q <= 1'b0;
      locked_q    <= 1'b0;
    end else if (frame_edge) begin
      case (lock_q)
        SEARCH: begin
          lock_q      <= MEASURE;
          match_cnt_q <= 1'b0;
        end
        MEASURE: begin
          if (!frame_match) begin
            match_cnt_q <= 1'b0;
          end else if (match_cnt_q) begin
            lock_q      <= LOCKED;
            locked_q    <= 1'b1;
            match_cnt_q <= 1'b0;
          end else begin
            match_cnt_q <= 1'b1;
          end
        end
        LOCKED: begin
          if (!frame_match) begin
            lock_q   <= SEARCH;
            locked_q <= 1'b0;
          end
        end
        default: begin
          lock_q   <= SEARCH;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  // A mismatched frame while armed or running is also the lock-loss event.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_q  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (cap_q)
        IDLE: begin
          if (capture_start && locked_q) begin
            cap_q  <= ARMED;
            busy_q <= 1'b1;
          end
        end
        ARMED, RUN: begin
          if (!locked_q || (frame_edge && !frame_match)) begin
            cap_q  <= IDLE;
            busy_q <= 1'b0;
            err_q  <= 1'b1;
          end else if (frame_edge) begin
            if (cap_q == ARMED) begin
              cap_q <= RUN;
            end else begin
              cap_q  <= IDLE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
        default: begin
          cap_q  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign wr_hit = (cap_q == RUN) && de_q && (x < HA_C) && (y < VA_C);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= wr_hit;
      if (wr_hit) begin
        wr_addr_q <= ADDR_WIDTH'(y) * ADDR_WIDTH'(HA) + ADDR_WIDTH'(x);
        wr_data_q <= {r_q[7:4], g_q[7:4], b_q[7:4]};
      end
    end
  end

  assign locked      = locked_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign capture_err = err_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign meas_width  = meas_width_q;
  assign meas_height = meas_height_q;

endmodule

// File: tb/tb_video_capture.sv
// Bench for video_capture: 640-wide, 4-line active frames (660x5 total) keep the
// run short while exercising lock, capture, abort and reset behaviour.
module tb_video_capture;

  localparam int HA = 640;
  localparam int VA = 4;
  localparam int HT = 660;
  localparam int VT = 5;
  localparam int AW = 18;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    vid_r = '0, vid_g = '0, vid_b = '0;
  logic          vid_hs = 1'b1, vid_vs = 1'b1, vid_de = 1'b0;
  logic          capture_start = 1'b0;
  logic          locked, busy, frame_done, capture_err, wr_en;
  logic [AW-1:0] wr_addr;
  logic [11:0]   wr_data;
  logic [9:0]    meas_width, meas_height, meas_htotal, meas_vtotal;

  video_capture #(.HA(HA), .VA(VA), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .vid_r(vid_r), .vid_g(vid_g), .vid_b(vid_b),
    .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_de(vid_de),
    .capture_start(capture_start),
    .locked(locked), .busy(busy), .frame_done(frame_done), .capture_err(capture_err),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .meas_width(meas_width), .meas_height(meas_height),
    .meas_htotal(meas_htotal), .meas_vtotal(meas_vtotal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [11:0]   data;
  } wr_t;

  typedef struct {
    int            x;
    int            y;
    logic [7:0]    r;
    logic [7:0]    g;
    logic [7:0]    b;
    logic [AW-1:0] addr;
    logic [11:0]   data;
  } pix_vec_t;

  wr_t           sb_q[$];
  logic [11:0]   cap_mem [int];
  pix_vec_t      vec [4];
  int            n_chk = 0, n_fail = 0;
  int            wr_cnt = 0, done_cnt = 0, err_cnt = 0;
  int            lock_rise_frame = 0, cur_frame = 0, cur_ln = 0, cur_px = 0;
  logic [AW-1:0] first_addr = '0, last_addr = '0;
  bit            prev_locked = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Runs once per cycle at the falling edge.
  task automatic monitor();
    wr_t e;
    if (wr_en) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL wr_unexpected: got write to addr %0d, expected no write", wr_addr);
      end else begin
        e = sb_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.addr));
        chk("wr_data", 32'(wr_data), 32'(e.data));
      end
      cap_mem[int'(wr_addr)] = wr_data;
      if (wr_cnt == 0) first_addr = wr_addr;
      last_addr = wr_addr;
      wr_cnt++;
    end
    if (frame_done || capture_err)
      chk("done_err_excl", 32'(frame_done & capture_err), 32'd0);
    if (frame_done) begin
      done_cnt++;
      chk("done_pos", cur_ln * HT + cur_px, VA * HT + 2);
    end
    if (capture_err) begin
      err_cnt++;
      chk("err_pos", cur_ln * HT + cur_px, VA * HT + 2);
    end
    if (locked && !prev_locked) lock_rise_frame = cur_frame;
    prev_locked = locked;
  endtask

  task automatic cyc(input logic vs, input logic hs, input logic de, input logic st,
                     input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    vid_vs = vs; vid_hs = hs; vid_de = de; capture_start = st;
    vid_r = r; vid_g = g; vid_b = b;
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic st);
    cyc(1'b1, 1'b1, 1'b0, st, 8'd0, 8'd0, 8'd0);
    repeat (n - 1) cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
  endtask

  task automatic reset_mid();
    reset = 1'b1; vid_de = 1'b0; capture_start = 1'b0;
    chk("wr_before_rst", wr_cnt, 2 * HA + 98);
    @(posedge clk);
    #1;
    chk("rst_ctrl", 32'({locked, busy, frame_done, capture_err, wr_en}), 32'd0);
    chk("rst_wr", 32'({wr_addr, wr_data}), 32'd0);
    chk("rst_meas_wh", 32'({meas_width, meas_height}), 32'd0);
    chk("rst_meas_tot", 32'({meas_htotal, meas_vtotal}), 32'd0);
    sb_q.delete();
    reset = 1'b0;
  endtask

  // One frame: VA active lines, then vs held low for the first blank line.
  task automatic frame(input bit cap, input int short_y, input bit pulse, input int abort_ln);
    logic [7:0] r, g, b;
    bit         act;
    wr_t        e;
    cur_frame++;
    for (int ln = 0; ln < VT; ln++) begin
      for (int px = 0; px < HT; px++) begin
        cur_ln = ln;
        cur_px = px;
        if (ln == abort_ln && px == 100) begin
          reset_mid();
          return;
        end
        act = (ln < VA) && (px < ((ln == short_y) ? HA - 1 : HA));
        r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
        for (int i = 0; i < 4; i++)
          if (vec[i].x == px && vec[i].y == ln) begin
            r = vec[i].r; g = vec[i].g; b = vec[i].b;
          end
        if (cap && act) begin
          e.addr = AW'(ln * HA + px);
          e.data = {r[7:4], g[7:4], b[7:4]};
          sb_q.push_back(e);
        end
        cyc(!(ln == VA), !(px >= HA + 4 && px < HA + 8), act, pulse && ln == 0 && px == 0,
            act ? r : 8'd0, act ? g : 8'd0, act ? b : 8'd0);
      end
    end
  endtask

  initial begin
    vec[0] = '{5,   2, 8'hAB, 8'hCD, 8'hEF, 18'd1285, 12'hACE};
    vec[1] = '{0,   0, 8'h12, 8'h34, 8'h56, 18'd0,    12'h135};
    vec[2] = '{639, 3, 8'hFF, 8'h00, 8'h80, 18'd2559, 12'hF08};
    vec[3] = '{100, 1, 8'h0F, 8'hF0, 8'h55, 18'd740,  12'h0F5};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", 32'({locked, busy, frame_done, capture_err, wr_en}), 32'd0);
    chk("reset_meas", 32'({meas_width, meas_height, wr_data}), 32'd0);
    reset = 1'b0;

    idle(6, 1'b1);
    chk("start_unlocked_busy", 32'(busy), 32'd0);

    frame(0, -1, 0, -1);
    frame(0, -1, 0, -1);
    chk("locked_after_f2", 32'(locked), 32'd0);
    frame(0, -1, 0, -1);
    chk("locked_after_f3", 32'(locked), 32'd1);
    chk("lock_rise_frame", lock_rise_frame, 3);
    chk("meas_width", 32'(meas_width), 32'd640);
    chk("meas_height", 32'(meas_height), 32'd4);
`ifdef VIDEO_CAPTURE_TIMING_EN
    chk("meas_htotal", 32'(meas_htotal), 32'd660);
    chk("meas_vtotal", 32'(meas_vtotal), 32'd5);
`else
    chk("meas_htotal", 32'(meas_htotal), 32'd0);
    chk("meas_vtotal", 32'(meas_vtotal), 32'd0);
`endif

    wr_cnt = 0;
    frame(0, -1, 1, -1);
    chk("busy_armed", 32'(busy), 32'd1);
    chk("no_wr_armed", wr_cnt, 0);
    frame(1, -1, 1, -1);
    chk("wr_count", wr_cnt, HA * VA);
    chk("first_addr", 32'(first_addr), 32'd0);
    chk("last_addr", 32'(last_addr), 32'd2559);
    chk("done_cnt", done_cnt, 1);
    chk("err_cnt", err_cnt, 0);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("sb_empty", sb_q.size(), 0);
    chk("locked_after_cap", 32'(locked), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (cap_mem.exists(int'(vec[i].addr)))
        chk("vec_data", 32'(cap_mem[int'(vec[i].addr)]), 32'(vec[i].data));
      else
        chk("vec_written", 32'd0, 32'd1);
    end

    frame(0, -1, 1, -1);
    wr_cnt = 0;
    frame(1, 1, 0, -1);
    chk("bad_err_cnt", err_cnt, 1);
    chk("bad_done_cnt", done_cnt, 1);
    chk("bad_locked", 32'(locked), 32'd0);
    chk("bad_busy", 32'(busy), 32'd0);
    chk("bad_wr_count", wr_cnt, HA * VA - 1);
    chk("bad_sb_empty", sb_q.size(), 0);

    frame(0, -1, 0, -1);
    frame(0, -1, 0, -1);
    frame(0, -1, 0, -1);
    chk("relocked", 32'(locked), 32'd1);
    chk("relock_frame", lock_rise_frame, 10);
    frame(0, -1, 1, -1);
    chk("rearmed_busy", 32'(busy), 32'd1);
    wr_cnt = 0;
    frame(1, -1, 0, 2);
    idle(10, 1'b1);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_err", err_cnt, 1);
    chk("post_rst_done", done_cnt, 1);
    chk("post_rst_locked", 32'(locked), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/video_capture.md
VIDEO_CAPTURE -- requirements
Module: video_capture

Interface
REQ-001 SHALL have parameter HA, default 640, expected active pixels per line.
REQ-002 SHALL have parameter VA, default 480, expected active lines per frame.
REQ-003 SHALL have parameter ADDR_WIDTH, default 18, write-address width.
REQ-004 SHALL have ports: clk  in  1  sole clock; reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports: vid_r, vid_g, vid_b  in  8 each  pixel colour; vid_hs, vid_vs  in  1  active-low syncs; vid_de  in  1  active video.
REQ-006 SHALL have port capture_start  in  1  single-cycle request to grab one frame.
REQ-007 SHALL have ports: locked  out  1  timing lock; busy  out  1  capture armed or running; frame_done  out  1  one-cycle pulse; capture_err  out  1  one-cycle pulse.
REQ-008 SHALL have ports: wr_en  out  1; wr_addr  out  ADDR_WIDTH  y*HA+x; wr_data  out  12  RGB444 {r[7:4],g[7:4],b[7:4]}.
REQ-009 SHALL have ports: meas_width, meas_height, meas_htotal, meas_vtotal  out  10 each  measured timing.

Function
REQ-010 SHALL register all video inputs once; all logic uses the registered copies.
REQ-011 Frame boundary = falling edge of registered vid_vs; line end = falling edge of registered vid_de.
REQ-012 x counter SHALL count de-high cycles, saturating at 1023, cleared at each line end; y SHALL increment at each line end, saturating at 1023, cleared at frame boundary.
REQ-013 At each line end meas_width SHALL load x; a frame-scoped width_err flag SHALL set if x != HA.
REQ-014 At each frame boundary meas_height SHALL load y; frame matches iff y == VA and width_err clear; width_err then clears.
REQ-015 Lock FSM states SEARCH, MEASURE, LOCKED; SEARCH->MEASURE on first frame boundary; MEASURE->LOCKED after 2 consecutive matching frames; mismatch in MEASURE resets match count; mismatch in LOCKED -> SEARCH.
REQ-016 locked SHALL be 1 only in LOCKED.
REQ-017 Capture FSM states IDLE, ARMED, RUN; IDLE->ARMED on capture_start while locked (ignored otherwise); ARMED->RUN at next frame boundary; RUN->IDLE at following frame boundary with frame_done pulse on that cycle if the frame matched.
REQ-018 busy SHALL be 1 in ARMED and RUN; capture_start while busy SHALL be ignored.
REQ-019 In RUN, each de-high cycle with x<HA and y<VA SHALL produce wr_en=1 one cycle after the registered sample, with wr_addr=y*HA+x and wr_data from that sample.
REQ-020 Lock loss or mismatched frame while ARMED/RUN SHALL abort to IDLE with a capture_err pulse, no frame_done; frame_done and capture_err never assert together.
REQ-021 Video with no vs edge SHALL leave all state unchanged beyond counter saturation.

Reset
REQ-022 On reset: lock FSM SEARCH, capture FSM IDLE, counters and measurements 0, all outputs 0; reset mid-capture aborts silently (no capture_err).
REQ-023 Reset SHALL take effect on the clk edge where sampled high and dominate capture_start.

Configuration
REQ-024 With VIDEO_CAPTURE_TIMING_EN defined, meas_htotal SHALL load clocks between consecutive vid_hs falling edges and meas_vtotal lines (hs falls) between frame boundaries, both saturating at 1023.
REQ-025 Without VIDEO_CAPTURE_TIMING_EN, meas_htotal and meas_vtotal SHALL be constant 0 and the total counters SHALL not be built; ports unchanged.

Structure
REQ-026 Shared package SHALL hold lock/capture state enums, RGB444 packing width constant, and default HA/VA.
REQ-027 Edge detection and x/y/total counting SHALL be sub-module video_timing_meter; capture FSM and write port stay in video_capture.

Verification
REQ-028 Reset then 3 frames of 640x480 (800x525 total) -> locked rises at 2nd frame boundary after first; meas_width=640, meas_height=480.
REQ-029 Locked, capture_start pulse -> busy=1; next frame yields 307200 wr_en pulses, first wr_addr=0, last 307199; frame_done one cycle at closing boundary.
REQ-030 Locked, one line with 639 active pixels -> locked drops at that frame boundary; if capturing, capture_err pulse, no frame_done.
REQ-031 Pixel (r,g,b)=(0xAB,0xCD,0xEF) at x=5,y=2 -> wr_addr=1285, wr_data=0xACE.
REQ-032 Reset asserted mid-RUN -> all outputs 0 next cycle, no capture_err; capture_start while unlocked -> busy stays 0.
REQ-033 With VIDEO_CAPTURE_TIMING_EN, 800x525 timing -> meas_htotal=800, meas_vtotal=525; without it both 0.
